// File: rtl/sim_run_ctrl.sv
// Run controller: sequences the CPU reset, counts RUN cycles and ends the run on a PC self-loop or a cycle-budget timeout.
// Outputs are registered or decoded from state; start is acted on at the next edge.
// No backpressure: start is honoured in every state, and DONE holds until the next start.
module sim_run_ctrl #(
  parameter int RESET_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 30000,
  parameter int HALT_REPEAT    = 4,
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 pc_valid,
  output logic                 cpu_reset,
  output logic                 running,
  output logic                 done,
  output logic                 halted,
  output logic                 timed_out,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int HOLD_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STREAK_W = $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STREAK_W-1:0]  HALT_N    = STREAK_W'(HALT_REPEAT);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [HOLD_W-1:0]     hold_cnt, hold_cnt_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [STREAK_W-1:0]   streak, streak_nxt, streak_upd;
  logic [PC_WIDTH-1:0]   last_pc, last_pc_nxt;
  logic                  halted_q, halted_nxt;
  logic                  timed_q, timed_nxt;

  // Streak value a valid cycle would produce: extend on a repeated PC, otherwise restart at one.
  always_comb begin
    streak_upd = STREAK_W'(1);
    if ((streak != '0) && (pc == last_pc)) begin
      streak_upd = streak + STREAK_W'(1);
    end
  end

  // Next-state and datapath update; start wins over everything and clears the run.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    cnt_nxt      = cnt;
    streak_nxt   = streak;
    last_pc_nxt  = last_pc;
    halted_nxt   = halted_q;
    timed_nxt    = timed_q;
    if (start) begin
      state_nxt    = RESET_HOLD;
      hold_cnt_nxt = '0;
      cnt_nxt      = '0;
      streak_nxt   = '0;
      last_pc_nxt  = '0;
      halted_nxt   = 1'b0;
      timed_nxt    = 1'b0;
    end else begin
      case (state)
        RESET_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = RUN;
          end else begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
          if (pc_valid) begin
            streak_nxt  = streak_upd;
            last_pc_nxt = pc;
          end
          // Halt is checked first so a halt landing on the timeout edge reports as a halt.
          if (pc_valid && (streak_upd == HALT_N)) begin
            state_nxt  = DONE;
            halted_nxt = 1'b1;
          end else if (cnt == TO_LAST) begin
            state_nxt = DONE;
            timed_nxt = 1'b1;
          end
        end
        default: begin
          // IDLE and DONE only leave on start.
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous master reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      cnt      <= '0;
      streak   <= '0;
      last_pc  <= '0;
      halted_q <= 1'b0;
      timed_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      cnt      <= cnt_nxt;
      streak   <= streak_nxt;
      last_pc  <= last_pc_nxt;
      halted_q <= halted_nxt;
      timed_q  <= timed_nxt;
    end
  end

  // CPU stays in reset while idle or holding; released in RUN and DONE so its state can be inspected.
  assign cpu_reset   = (state == IDLE) || (state == RESET_HOLD);
  assign running     = (state == RUN);
  assign done        = (state == DONE);
  assign halted      = halted_q;
  assign timed_out   = timed_q;
  assign cycle_count = cnt;

endmodule
